// File: rtl/signed_or_unsigned_div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// The counter width is derived from the operand width so the counter can hold n itself.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FIX,
        DONE
    } div_state_e;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/signed_or_unsigned_div_if.sv
// Operand and result handshake bundle for signed_or_unsigned_div.
// Defining SIGNED_OR_UNSIGNED_DIV_STATUS_EN adds the div_by_zero/overflow status lines.
interface signed_or_unsigned_div_if #(parameter int n = 8);

    logic         arg_vld;
    logic         arg_rdy;
    logic [n-1:0] a;
    logic [n-1:0] b;
    logic         signed_div;
    logic         res_vld;
    logic         res_rdy;
    logic [n-1:0] quot;
    logic [n-1:0] rem;

`ifdef SIGNED_OR_UNSIGNED_DIV_STATUS_EN
    logic         div_by_zero;
    logic         overflow;

    modport master (
        output arg_vld, a, b, signed_div, res_rdy,
        input  arg_rdy, res_vld, quot, rem, div_by_zero, overflow
    );

    modport slave (
        input  arg_vld, a, b, signed_div, res_rdy,
        output arg_rdy, res_vld, quot, rem, div_by_zero, overflow
    );
`else
    modport master (
        output arg_vld, a, b, signed_div, res_rdy,
        input  arg_rdy, res_vld, quot, rem
    );

    modport slave (
        input  arg_vld, a, b, signed_div, res_rdy,
        output arg_rdy, res_vld, quot, rem
    );
`endif

endinterface

// File: rtl/signed_or_unsigned_div_restore_step.sv
// One restoring-division iteration: shift in the next dividend bit and trial-subtract the divisor.
module div_restore_step #(
    parameter int n = 8
) (
    input  logic [n:0]   rem_in,
    input  logic         dividend_bit,
    input  logic [n-1:0] divisor,
    output logic [n:0]   rem_out,
    output logic         quot_bit
);

    logic [n+1:0] shifted;
    logic [n+1:0] diff;

    always_comb begin
        shifted  = {rem_in, dividend_bit};
        diff     = shifted - {2'b00, divisor};
        quot_bit = (shifted >= {2'b00, divisor});
        rem_out  = quot_bit ? (n+1)'(diff) : (n+1)'(shifted);
    end

endmodule

// File: rtl/signed_or_unsigned_div.sv
// Multi-cycle signed/unsigned restoring divider behind valid/ready handshakes.
// Build option SIGNED_OR_UNSIGNED_DIV_STATUS_EN adds div_by_zero and overflow status outputs.
module signed_or_unsigned_div #(
    parameter int n = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    signed_or_unsigned_div_if.slave  bus
);

    import div_pkg::*;

    localparam int CW = cnt_width(n);

    div_state_e    state;
    logic [CW-1:0] cnt;
    logic [n:0]    rem_q;
    logic [n-1:0]  quot_q;
    logic [n-1:0]  mag_b;
    logic          neg_quot;
    logic          neg_rem;
    logic          arg_rdy_q;
    logic          res_vld_q;

    logic          accept;
    logic [n-1:0]  mag_a_in;
    logic [n-1:0]  mag_b_in;
    logic [n:0]    step_rem;
    logic          step_bit;

    // Magnitudes are n-bit unsigned, so |smin| = 2^(n-1) fits without overflow.
    always_comb begin
        accept   = (state == IDLE) && bus.arg_vld && arg_rdy_q;
        mag_a_in = (bus.signed_div && bus.a[n-1]) ? -bus.a : bus.a;
        mag_b_in = (bus.signed_div && bus.b[n-1]) ? -bus.b : bus.b;
    end

    div_restore_step #(.n(n)) u_step (
        .rem_in       (rem_q),
        .dividend_bit (quot_q[n-1]),
        .divisor      (mag_b),
        .rem_out      (step_rem),
        .quot_bit     (step_bit)
    );

    // quot_q starts as the dividend magnitude and fills with quotient bits from the right.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            mag_b     <= '0;
            neg_quot  <= 1'b0;
            neg_rem   <= 1'b0;
            arg_rdy_q <= 1'b0;
            res_vld_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    arg_rdy_q <= 1'b1;
                    if (accept) begin
                        arg_rdy_q <= 1'b0;
                        mag_b     <= mag_b_in;
                        neg_quot  <= bus.signed_div & (bus.a[n-1] ^ bus.b[n-1]);
                        neg_rem   <= bus.signed_div & bus.a[n-1];
                        if (bus.b == '0) begin
                            quot_q    <= '1;
                            rem_q     <= {1'b0, bus.a};
                            res_vld_q <= 1'b1;
                            state     <= DONE;
                        end else begin
                            quot_q <= mag_a_in;
                            rem_q  <= '0;
                            cnt    <= CW'(n);
                            state  <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    rem_q  <= step_rem;
                    quot_q <= {quot_q[n-2:0], step_bit};
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (neg_quot) begin
                        quot_q <= -quot_q;
                    end
                    if (neg_rem) begin
                        rem_q <= {1'b0, -rem_q[n-1:0]};
                    end
                    res_vld_q <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (bus.res_rdy) begin
                        res_vld_q <= 1'b0;
                        arg_rdy_q <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SIGNED_OR_UNSIGNED_DIV_STATUS_EN
    logic div_by_zero_q;
    logic overflow_q;

    // Flags are captured with the operands and stay put until the next acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_by_zero_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else if (accept) begin
            div_by_zero_q <= (bus.b == '0);
            overflow_q    <= bus.signed_div && (bus.a == {1'b1, {(n-1){1'b0}}}) && (bus.b == '1);
        end
    end

    assign bus.div_by_zero = div_by_zero_q;
    assign bus.overflow    = overflow_q;
`endif

    assign bus.arg_rdy = arg_rdy_q;
    assign bus.res_vld = res_vld_q;
    assign bus.quot    = quot_q;
    assign bus.rem     = rem_q[n-1:0];

endmodule

// File: tb/tb_signed_or_unsigned_div.sv
// Directed-vector bench for signed_or_unsigned_div at n=4, plus handshake, sweep and reset sequences.
// Latency is counted in rising edges, with the edge that samples the handshake counted as edge 1.
module tb_signed_or_unsigned_div;

    localparam int N = 4;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       sgn;
        logic [3:0] q;
        logic [3:0] r;
        int         lat;
        logic       dbz;
        logic       ovf;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   compared   = 0;
    int   mismatched = 0;
    vec_t vecs[12];

    always #5 clk = ~clk;

    signed_or_unsigned_div_if #(.n(N)) bus ();

    signed_or_unsigned_div #(.n(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Presents one operand pair and waits (bounded) for the result; leaves the result unacknowledged.
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic sgn,
                                 output logic [3:0] q, output logic [3:0] r, output int lat,
                                 output logic dbz, output logic ovf, output bit ok);
        int waited = 0;
        ok  = 1'b0;
        q   = '0;
        r   = '0;
        lat = 0;
        dbz = 1'b0;
        ovf = 1'b0;
        while (bus.arg_rdy !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (bus.arg_rdy !== 1'b1) begin
            checkOutput("arg_rdy_timeout", {31'd0, bus.arg_rdy}, 32'd1);
            return;
        end
        bus.arg_vld    = 1'b1;
        bus.a          = a;
        bus.b          = b;
        bus.signed_div = sgn;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            bus.arg_vld = 1'b0;
            bus.a       = ~a;
            bus.b       = ~b;
        end while (bus.res_vld !== 1'b1 && lat < 40);
        if (bus.res_vld !== 1'b1) begin
            checkOutput("res_vld_timeout", {31'd0, bus.res_vld}, 32'd1);
            return;
        end
        q = bus.quot;
        r = bus.rem;
`ifdef SIGNED_OR_UNSIGNED_DIV_STATUS_EN
        dbz = bus.div_by_zero;
        ovf = bus.overflow;
`endif
        ok = 1'b1;
    endtask

    task automatic releaseResult();
        bus.res_rdy = 1'b1;
        @(negedge clk);
        bus.res_rdy = 1'b0;
    endtask

    task automatic verifyVector(input vec_t v, input string tag);
        logic [3:0] q;
        logic [3:0] r;
        int         lat;
        logic       dbz;
        logic       ovf;
        bit         ok;
        applyStimulus(v.a, v.b, v.sgn, q, r, lat, dbz, ovf, ok);
        if (ok) begin
            checkOutput({tag, "_quot"}, {28'd0, q}, {28'd0, v.q});
            checkOutput({tag, "_rem"}, {28'd0, r}, {28'd0, v.r});
            checkOutput({tag, "_latency"}, lat, v.lat);
`ifdef SIGNED_OR_UNSIGNED_DIV_STATUS_EN
            checkOutput({tag, "_div_by_zero"}, {31'd0, dbz}, {31'd0, v.dbz});
            checkOutput({tag, "_overflow"}, {31'd0, ovf}, {31'd0, v.ovf});
`endif
            releaseResult();
        end
    endtask

    function automatic vec_t refModel(input logic [3:0] a, input logic [3:0] b, input logic sgn);
        vec_t v;
        int   ia;
        int   ib;
        int   qi;
        int   ri;
        v.a   = a;
        v.b   = b;
        v.sgn = sgn;
        v.dbz = (b == 4'd0);
        v.ovf = sgn && (a == 4'h8) && (b == 4'hF);
        if (b == 4'd0) begin
            v.q   = 4'hF;
            v.r   = a;
            v.lat = 1;
        end else begin
            ia = sgn ? {{28{a[3]}}, a} : {28'd0, a};
            ib = sgn ? {{28{b[3]}}, b} : {28'd0, b};
            qi = ia / ib;
            ri = ia % ib;
            v.q   = qi[3:0];
            v.r   = ri[3:0];
            v.lat = N + 2;
        end
        return v;
    endfunction

    initial begin
        logic [3:0] q;
        logic [3:0] r;
        int         lat;
        logic       dbz;
        logic       ovf;
        bit         ok;
        vec_t       v;

        bus.arg_vld    = 1'b0;
        bus.a          = '0;
        bus.b          = '0;
        bus.signed_div = 1'b0;
        bus.res_rdy    = 1'b0;

        vecs[0]  = '{4'd13, 4'd3,  1'b0, 4'd4,  4'd1,  6, 1'b0, 1'b0};
        vecs[1]  = '{4'h9,  4'd2,  1'b1, 4'hD,  4'hF,  6, 1'b0, 1'b0};
        vecs[2]  = '{4'd7,  4'hE,  1'b1, 4'hD,  4'd1,  6, 1'b0, 1'b0};
        vecs[3]  = '{4'h8,  4'hF,  1'b1, 4'h8,  4'd0,  6, 1'b0, 1'b1};
        vecs[4]  = '{4'd5,  4'd0,  1'b0, 4'hF,  4'd5,  1, 1'b1, 1'b0};
        vecs[5]  = '{4'd5,  4'd0,  1'b1, 4'hF,  4'd5,  1, 1'b1, 1'b0};
        vecs[6]  = '{4'd0,  4'd3,  1'b1, 4'd0,  4'd0,  6, 1'b0, 1'b0};
        vecs[7]  = '{4'd2,  4'd7,  1'b0, 4'd0,  4'd2,  6, 1'b0, 1'b0};
        vecs[8]  = '{4'hE,  4'd5,  1'b1, 4'd0,  4'hE,  6, 1'b0, 1'b0};
        vecs[9]  = '{4'd15, 4'd1,  1'b0, 4'd15, 4'd0,  6, 1'b0, 1'b0};
        vecs[10] = '{4'h8,  4'hF,  1'b0, 4'd0,  4'd8,  6, 1'b0, 1'b0};
        vecs[11] = '{4'hF,  4'd0,  1'b1, 4'hF,  4'hF,  1, 1'b1, 1'b0};

        #12;
        checkOutput("reset_res_vld", {31'd0, bus.res_vld}, 32'd0);
        checkOutput("reset_quot", {28'd0, bus.quot}, 32'd0);
        checkOutput("reset_rem", {28'd0, bus.rem}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_arg_rdy", {31'd0, bus.arg_rdy}, 32'd1);

        for (int i = 0; i < 12; i++) begin
            verifyVector(vecs[i], $sformatf("vec%0d", i));
        end

        // Result held while the consumer stalls, and no operand slips in on the release cycle.
        applyStimulus(4'd6, 4'd4, 1'b0, q, r, lat, dbz, ovf, ok);
        if (ok) begin
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                checkOutput($sformatf("hold%0d_res_vld", c), {31'd0, bus.res_vld}, 32'd1);
                checkOutput($sformatf("hold%0d_quot", c), {28'd0, bus.quot}, 32'd1);
                checkOutput($sformatf("hold%0d_rem", c), {28'd0, bus.rem}, 32'd2);
                checkOutput($sformatf("hold%0d_arg_rdy", c), {31'd0, bus.arg_rdy}, 32'd0);
            end
            bus.res_rdy    = 1'b1;
            bus.arg_vld    = 1'b1;
            bus.a          = 4'd3;
            bus.b          = 4'd1;
            bus.signed_div = 1'b0;
            checkOutput("release_cycle_arg_rdy", {31'd0, bus.arg_rdy}, 32'd0);
            @(negedge clk);
            bus.res_rdy = 1'b0;
            bus.arg_vld = 1'b0;
            checkOutput("after_release_res_vld", {31'd0, bus.res_vld}, 32'd0);
            checkOutput("after_release_arg_rdy", {31'd0, bus.arg_rdy}, 32'd1);
        end

        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    v = refModel(4'(a), 4'(b), 1'(s));
                    verifyVector(v, $sformatf("sweep_s%0d_a%0d_b%0d", s, a, b));
                end
            end
        end

        // Reset in the middle of an operation, then a clean operation afterwards.
        @(negedge clk);
        bus.arg_vld    = 1'b1;
        bus.a          = 4'd13;
        bus.b          = 4'd3;
        bus.signed_div = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.arg_vld = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midbusy_reset_res_vld", {31'd0, bus.res_vld}, 32'd0);
        checkOutput("midbusy_reset_quot", {28'd0, bus.quot}, 32'd0);
        checkOutput("midbusy_reset_rem", {28'd0, bus.rem}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rerelease_arg_rdy", {31'd0, bus.arg_rdy}, 32'd1);
        checkOutput("rerelease_res_vld", {31'd0, bus.res_vld}, 32'd0);
        v = '{4'd9, 4'd4, 1'b0, 4'd2, 4'd1, 6, 1'b0, 1'b0};
        verifyVector(v, "after_reset_9_div_4");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
